nios_system_encoder_out_gen: RTL and testbench

Avalon-MM slave that synthesizes quadrature encoder signals (A/B, optional Z) under Nios II software control. It is the transmit-side counterpart of the encoder input PIO. Software writes a signed step count and an edge period. The block then emits that many quadrature transitions and tracks a running position. It drives motor-encoder loopback in the Qsys test system and emulates encoders in hardware-in-the-loop.

---
 rtl/nios_system_encoder_out_gen.sv | 156 +++++++++++++++
 tb/tb_nios_system_encoder_out_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_encoder_out_gen.sv
// Avalon-MM quadrature encoder generator: emits signed step moves on A/B at a programmable edge period.
// Optional index channel (enc_z) is compiled in with `define ENCODER_OUT_INDEX_EN.
module nios_system_encoder_out_gen #(
  parameter int unsigned PERIOD_W       = 16,
  parameter int unsigned DEFAULT_PERIOD = 50,
  parameter int unsigned COUNTS_PER_REV = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        enc_a,
  output logic        enc_b,
`ifdef ENCODER_OUT_INDEX_EN
  output logic        enc_z,
`endif
  output logic        busy
);

  logic [31:0]         readdata_q, readdata_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [31:0]         position_q, position_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [1:0]          ab_q, ab_d;
  logic                dir_q, dir_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                z_d;

  logic                wr_en, steps_wr, period_wr, status_wr, pos_wr, abort;
  logic                active, step;
  logic [31:0]         steps_mag;
  logic [PERIOD_W-1:0] reload;

`ifdef ENCODER_OUT_INDEX_EN
  localparam int unsigned IDX_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(COUNTS_PER_REV - 1);
  logic [IDX_W-1:0] index_q, index_d;
  logic             enc_z_q;
`else
  logic unused_cpr;
  assign unused_cpr = (COUNTS_PER_REV == 0);
`endif

  always_comb begin
    wr_en     = chipselect & ~write_n;
    steps_wr  = wr_en && (address == 2'd0);
    period_wr = wr_en && (address == 2'd1);
    status_wr = wr_en && (address == 2'd2);
    pos_wr    = wr_en && (address == 2'd3);
    abort     = status_wr && writedata[0];
    active    = (remaining_q != '0);
    step      = active && (presc_q == '0) && !abort;
    steps_mag = writedata[31] ? (~writedata + 32'd1) : writedata;
    reload    = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

    remaining_d = remaining_q;
    dir_d       = dir_q;
    presc_d     = presc_q;
    overrun_d   = overrun_q;
    period_d    = period_q;
    position_d  = position_q;
    ab_d        = ab_q;

    if (active) presc_d = (presc_q == '0) ? reload : presc_q - PERIOD_W'(1);

    // A step uses the pre-write direction; a same-cycle STEPS write only
    // replaces the request, so a reversal takes effect from the next step.
    if (step) begin
      remaining_d = remaining_q - 32'd1;
      ab_d        = dir_q ? {ab_q[0], ~ab_q[1]} : {~ab_q[0], ab_q[1]};
      position_d  = dir_q ? position_q - 32'd1 : position_q + 32'd1;
    end

    if (steps_wr && !abort) begin
      remaining_d = steps_mag;
      dir_d       = writedata[31];
      if (active) overrun_d = 1'b1;
      else        presc_d   = reload;
    end
    if (abort) remaining_d = '0;
    if (status_wr && writedata[2]) overrun_d = 1'b0;
    if (period_wr) period_d = writedata[PERIOD_W-1:0];
    if (pos_wr) position_d = writedata;

    busy_d = busy_q ? (remaining_d != '0) : (active && remaining_d != '0);

`ifdef ENCODER_OUT_INDEX_EN
    index_d = index_q;
    if (step) begin
      if (dir_q) index_d = (index_q == '0) ? IDX_MAX : index_q - IDX_W'(1);
      else       index_d = (index_q == IDX_MAX) ? '0 : index_q + IDX_W'(1);
    end
    if (pos_wr) index_d = '0;
    z_d = (index_d == '0);
`else
    z_d = 1'b0;
`endif

    // readdata reflects register contents after this edge, so a STEPS read
    // on the final-step edge already returns 0.
    case (address)
      2'd0:    readdata_d = remaining_d;
      2'd1:    readdata_d = 32'(period_d);
      2'd2:    readdata_d = {28'd0, z_d, overrun_d, dir_d, busy_d};
      default: readdata_d = position_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q  <= '0;
      remaining_q <= '0;
      position_q  <= '0;
      period_q    <= PERIOD_W'(DEFAULT_PERIOD);
      presc_q     <= '0;
      ab_q        <= '0;
      dir_q       <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      ab_q        <= ab_d;
      dir_q       <= dir_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ENCODER_OUT_INDEX_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= '0;
      enc_z_q <= 1'b1;
    end else begin
      index_q <= index_d;
      enc_z_q <= z_d;
    end
  end
  assign enc_z = enc_z_q;
`endif

  assign readdata = readdata_q;
  assign enc_a    = ab_q[1];
  assign enc_b    = ab_q[0];
  assign busy     = busy_q;

endmodule

// File: tb/tb_nios_system_encoder_out_gen.sv
// Self-checking bench for nios_system_encoder_out_gen against a timeline model of moves.
module tb_nios_system_encoder_out_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        enc_a, enc_b, busy;
`ifdef ENCODER_OUT_INDEX_EN
  logic        enc_z;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_ph    = 0;
  int m_pos   = 0;
  logic [31:0] rdv;

  nios_system_encoder_out_gen #(
    .PERIOD_W(16),
    .DEFAULT_PERIOD(50),
    .COUNTS_PER_REV(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .enc_a(enc_a),
    .enc_b(enc_b),
`ifdef ENCODER_OUT_INDEX_EN
    .enc_z(enc_z),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Forward quadrature order 00,10,11,01 indexed by phase.
  function automatic logic [1:0] ab_of(input int ph);
    case (((ph % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  // Step i of a k-step move lands at edge N + i*P; busy spans N+1 .. N+k*P-1.
  task automatic run_move(input int p, input int s);
    int pe, k, sd, cur;
    logic dir;
    logic [31:0] r;
    pe  = (p == 0) ? 1 : p;
    k   = (s < 0) ? -s : s;
    dir = (s < 0);
    wr(2'd1, 32'(p));
    wr(2'd0, 32'(s));
    cur = m_ph;
    for (int e = 1; e <= k * pe + 2; e++) begin
      @(posedge clk); #1;
      sd  = (e / pe < k) ? e / pe : k;
      cur = dir ? m_ph - sd : m_ph + sd;
      check("ab", 32'({enc_a, enc_b}), 32'(ab_of(cur)));
      check("busy", 32'(busy), 32'(e < k * pe));
      check("steps_rd", readdata, 32'(k - sd));
    end
    m_ph  = cur;
    m_pos = dir ? m_pos - k : m_pos + k;
    rd(2'd3, r);
    check("position", r, 32'(m_pos));
    rd(2'd2, r);
    check("status", r & 32'h7, {30'd0, dir, 1'b0});
  endtask

  initial begin
    int p, k, s;
    logic [31:0] v;

    repeat (3) @(posedge clk);
    #1;
    check("rst_a", 32'(enc_a), 32'd0);
    check("rst_b", 32'(enc_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", readdata, 32'd0);
`ifdef ENCODER_OUT_INDEX_EN
    check("rst_z", 32'(enc_z), 32'd1);
`endif
    reset_n = 1'b1;
    rd(2'd1, rdv); check("rst_period", rdv, 32'd50);
    rd(2'd3, rdv); check("rst_pos", rdv, 32'd0);
    rd(2'd2, rdv); check("rst_status", rdv & 32'h7, 32'd0);
    rd(2'd0, rdv); check("rst_steps", rdv, 32'd0);

    run_move(4, 5);
    wr(2'd3, 32'd0); m_pos = 0;
    run_move(1, -3);
    run_move(0, 2);

    wr(2'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("zero_busy", 32'(busy), 32'd0);
    end

    // Overrun: replace a 100-step move after 10 steps with a 2-step one.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd100);
    repeat (20) @(posedge clk);
    #1;
    wr(2'd0, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    check("ovr_busy", 32'(busy), 32'd0);
    rd(2'd2, rdv); check("ovr_set", rdv & 32'h4, 32'h4);
    m_pos += 12; m_ph += 12;
    rd(2'd3, rdv); check("ovr_pos", rdv, 32'(m_pos));
    check("ovr_ab", 32'({enc_a, enc_b}), 32'(ab_of(m_ph)));
    wr(2'd2, 32'h4);
    rd(2'd2, rdv); check("ovr_clr", rdv & 32'h4, 32'h0);

    // Abort after 7 steps.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd1000);
    repeat (7) @(posedge clk);
    #1;
    wr(2'd2, 32'h1);
    check("abort_busy", 32'(busy), 32'd0);
    m_pos += 7; m_ph += 7;
    rd(2'd0, rdv); check("abort_steps", rdv, 32'd0);
    rd(2'd3, rdv); check("abort_pos", rdv, 32'(m_pos));
    repeat (3) @(posedge clk);
    #1;
    check("abort_ab", 32'({enc_a, enc_b}), 32'(ab_of(m_ph)));

    // Largest negative request is a 2^31-step reverse move; abort it at once.
    wr(2'd0, 32'h8000_0000);
    check("neg_max", readdata, 32'h8000_0000);
    wr(2'd2, 32'h1);
    check("neg_max_busy", 32'(busy), 32'd0);
    wr(2'd2, 32'h4);

    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      wr(2'd3, v); m_pos = int'(v);
      rd(2'd3, rdv); check("pos_wr", rdv, v);
    end

    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 5));
      k = int'($urandom_range(1, 12));
      s = ($urandom_range(0, 1) == 1) ? -k : k;
      run_move(p, s);
    end

`ifdef ENCODER_OUT_INDEX_EN
    wr(2'd3, 32'd0); m_pos = 0;
    check("idx_reset_z", 32'(enc_z), 32'd1);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd8);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      check("idx_z", 32'(enc_z), 32'(e % 8 == 0));
    end
    m_pos += 8; m_ph += 8;
    run_move(1, -1);
    check("idx_rev_z", 32'(enc_z), 32'd0);
    rd(2'd2, rdv); check("idx_status_z", rdv & 32'h8, 32'h0);
    run_move(1, 1);
    check("idx_fwd_z", 32'(enc_z), 32'd1);
    rd(2'd2, rdv); check("idx_status_z1", rdv & 32'h8, 32'h8);
`else
    rd(2'd2, rdv); check("status_z", rdv & 32'h8, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
